// File: rtl/change_tally.sv
// change_tally: receive side of the change-dispense interface.
// Synchronizes the four coin-eject strobes, tallies the coins actually paid
// out, and compares that total against the expected change latched at start.
// Reports completion (done), match, overpay, underpay (timeout) and stray coins.

module change_tally #(
   parameter int unsigned TIMEOUT = 300000000,
   parameter int unsigned TO_W    = 29
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] expected,
   input  logic       qian1,
   input  logic       qian5,
   input  logic       qian10,
   input  logic       qian50,
   output logic [7:0] returned,
   output logic       busy,
   output logic       done,
   output logic       match,
   output logic       overpay,
   output logic       underpay,
   output logic       stray
);

   typedef enum logic [1:0] {StIdle, StCollect, StDone, StErr} state_e;

   // Bit order of the coin vectors: [0]=1, [1]=5, [2]=10, [3]=50 yuan.
   logic [3:0] coin_in;
   logic [3:0] meta_q, sync_q, prev_q;
   logic [3:0] edge_w;
   logic [1:0] arm_q;
   logic       armed;

   state_e          state_q, state_d;
   logic [7:0]      exp_q, exp_d;
   logic [7:0]      returned_q, returned_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            match_q, match_d;
   logic            overpay_q, overpay_d;
   logic            underpay_q, underpay_d;
   logic            stray_q, stray_d;

   logic [8:0]      sum_w;
   logic [7:0]      sum_sat;
   logic            any_edge;

   assign coin_in = {qian50, qian10, qian5, qian1};

   // Edges are masked until the synchronizer has filled after reset, so a level
   // already high at reset release is absorbed without being seen as a coin.
   assign armed    = (arm_q == 2'd3);
   assign edge_w   = sync_q & ~prev_q & {4{armed}};
   assign any_edge = |edge_w;

   // Two-flop synchronizer, previous-value register and post-reset arming count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 4'b0;
         sync_q <= 4'b0;
         prev_q <= 4'b0;
         arm_q  <= 2'd0;
      end else begin
         meta_q <= coin_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
         if (!armed) begin
            arm_q <= arm_q + 2'd1;
         end
      end
   end

   // Tally with simultaneous edges summed, computed at 9 bits and saturated.
   always_comb begin
      sum_w = {1'b0, returned_q}
            + (edge_w[0] ? 9'd1  : 9'd0)
            + (edge_w[1] ? 9'd5  : 9'd0)
            + (edge_w[2] ? 9'd10 : 9'd0)
            + (edge_w[3] ? 9'd50 : 9'd0);
      sum_sat = sum_w[8] ? 8'hff : sum_w[7:0];
   end

   // Next-state, tally, timeout and flag logic.
   always_comb begin
      state_d    = state_q;
      exp_d      = exp_q;
      returned_d = returned_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      match_d    = match_q;
      overpay_d  = overpay_q;
      underpay_d = underpay_q;
      stray_d    = stray_q;

      unique case (state_q)
         StCollect: begin
            if (any_edge) begin
               returned_d = sum_sat;
               cnt_d      = TO_W'(TIMEOUT);
               if (sum_sat == exp_q) begin
                  state_d = StDone;
                  match_d = 1'b1;
                  done_d  = 1'b1;
               end else if (sum_sat > exp_q) begin
                  state_d   = StErr;
                  overpay_d = 1'b1;
                  done_d    = 1'b1;
               end
            end else if (cnt_q <= TO_W'(1)) begin
               // Counter reaches zero on this edge: TIMEOUT cycles since reload.
               cnt_d      = '0;
               state_d    = StErr;
               underpay_d = 1'b1;
               done_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - TO_W'(1);
            end
         end
         default: begin
            // StIdle, StDone and StErr all accept a new start.
            if (start) begin
               returned_d = 8'd0;
               match_d    = 1'b0;
               overpay_d  = 1'b0;
               underpay_d = 1'b0;
               stray_d    = 1'b0;
               if (expected == 8'd0) begin
                  state_d = StDone;
                  match_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = StCollect;
                  exp_d   = expected;
                  cnt_d   = TO_W'(TIMEOUT);
               end
            end else if (any_edge) begin
               stray_d = 1'b1;
            end
         end
      endcase

      busy_d = (state_d == StCollect);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         exp_q      <= 8'd0;
         returned_q <= 8'd0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         match_q    <= 1'b0;
         overpay_q  <= 1'b0;
         underpay_q <= 1'b0;
         stray_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         exp_q      <= exp_d;
         returned_q <= returned_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         match_q    <= match_d;
         overpay_q  <= overpay_d;
         underpay_q <= underpay_d;
         stray_q    <= stray_d;
      end
   end

   assign returned = returned_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign match    = match_q;
   assign overpay  = overpay_q;
   assign underpay = underpay_q;
   assign stray    = stray_q;

endmodule
